// File: rtl/mac_operand_loader_pkg.sv
// rtl/mac_operand_loader_pkg.sv - shared widths and FSM encoding for the MAC operand loader
//   MAC_OP_W     operand width in bits
//   MAC_WORD_W   input stream word width in bits
//   opld_state_e loader control states (FILL accepts words, HOLD freezes a complete pair)
package mac_operand_loader_pkg;

  localparam int MAC_OP_W   = 256;
  localparam int MAC_WORD_W = 32;

  typedef enum logic {
    OPLD_FILL = 1'b0,
    OPLD_HOLD = 1'b1
  } opld_state_e;

endpackage

// File: rtl/mac_opld_asm_reg.sv
// rtl/mac_opld_asm_reg.sv - OP_W assembly register with single indexed word write per cycle
//   clk, rst_n  clock, asynchronous active-low reset (register clears to 0)
//   we          write enable for word idx
//   idx         word index, 0 = least-significant word
//   wdata       word to write
//   q           current register contents
module mac_opld_asm_reg #(
  parameter int OP_W   = 256,
  parameter int WORD_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [OP_W-1:0]   q
);

  logic [OP_W-1:0] q_q;
  logic [OP_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (we) begin
      q_d[idx*WORD_W +: WORD_W] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mac_operand_loader.sv
// rtl/mac_operand_loader.sv - assembles A/B operand pairs from a word stream for the MAC datapath
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              drop the partial (or frozen) pair, restart at word 0
//   s_valid/s_ready    input word handshake, s_data = word (LS word first, A then B)
//   op_valid/op_ready  output pair handshake, a_out/b_out = operands
//   OPLD_LAST_CHK_EN   adds s_last framing input and sticky err output
module mac_operand_loader
  import mac_operand_loader_pkg::*;
#(
  parameter int OP_W   = MAC_OP_W,
  parameter int WORD_W = MAC_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [OP_W-1:0]   a_out,
  output logic [OP_W-1:0]   b_out
`ifdef OPLD_LAST_CHK_EN
  ,
  input  logic              s_last,
  output logic              err
`endif
);

  localparam int NW    = OP_W / WORD_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int CNT_W = $clog2(2 * NW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * NW - 1);
  localparam logic [CNT_W-1:0] CNT_NW   = CNT_W'(NW);

  opld_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_valid_q, op_valid_d;
  logic [OP_W-1:0]  a_out_q, a_out_d;
  logic [OP_W-1:0]  b_out_q, b_out_d;
  logic             err_q, err_d;

  logic [OP_W-1:0]  a_asm;
  logic [OP_W-1:0]  b_asm;
  logic             accept;
  logic             is_last;
  logic             frame_err;
  logic             last_ok;
  logic             slot_free;
  logic             in_a;

  // Flush beats a simultaneous word; the word is simply not taken.
  assign accept    = s_valid & s_ready & ~flush;
  assign is_last   = (cnt_q == CNT_LAST);
  assign in_a      = (cnt_q < CNT_NW);
  assign slot_free = ~op_valid_q | op_ready;

`ifdef OPLD_LAST_CHK_EN
  assign frame_err = accept & (s_last != is_last);
  assign err       = err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign last_ok = accept & is_last & ~frame_err;

  // Words of a mis-framed pair still land in the assembly; they are overwritten
  // before any pair built from them could be presented.
  mac_opld_asm_reg #(.OP_W(OP_W), .WORD_W(WORD_W), .IDX_W(IDX_W)) u_asm_a (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept & in_a),
    .idx   (IDX_W'(cnt_q)),
    .wdata (s_data),
    .q     (a_asm)
  );

  mac_opld_asm_reg #(.OP_W(OP_W), .WORD_W(WORD_W), .IDX_W(IDX_W)) u_asm_b (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept & ~in_a),
    .idx   (IDX_W'(cnt_q - CNT_NW)),
    .wdata (s_data),
    .q     (b_asm)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_valid_d = op_valid_q;
    a_out_d    = a_out_q;
    b_out_d    = b_out_q;
    err_d      = err_q;

    if (flush) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (frame_err) begin
      cnt_d = '0;
      err_d = 1'b1;
    end else if (accept) begin
      cnt_d = is_last ? '0 : cnt_q + 1'b1;
    end

    if (op_valid_q & op_ready) begin
      op_valid_d = 1'b0;
    end

    case (state_q)
      OPLD_FILL: begin
        if (last_ok) begin
          if (slot_free) begin
            // The last word is still in flight to the B assembly, so bypass it.
            a_out_d = a_asm;
            b_out_d = b_asm;
            b_out_d[OP_W-WORD_W +: WORD_W] = s_data;
            op_valid_d = 1'b1;
          end else begin
            state_d = OPLD_HOLD;
          end
        end
      end
      OPLD_HOLD: begin
        if (flush) begin
          state_d = OPLD_FILL;
        end else if (op_valid_q & op_ready) begin
          a_out_d    = a_asm;
          b_out_d    = b_asm;
          op_valid_d = 1'b1;
          state_d    = OPLD_FILL;
        end
      end
      default: state_d = OPLD_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OPLD_FILL;
      cnt_q      <= '0;
      op_valid_q <= 1'b0;
      a_out_q    <= '0;
      b_out_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_valid_q <= op_valid_d;
      a_out_q    <= a_out_d;
      b_out_q    <= b_out_d;
      err_q      <= err_d;
    end
  end

  // Registered only: no path from op_ready to s_ready.
  assign s_ready  = (state_q == OPLD_FILL);
  assign op_valid = op_valid_q;
  assign a_out    = a_out_q;
  assign b_out    = b_out_q;

endmodule

// File: tb/tb_mac_operand_loader.sv
// tb/tb_mac_operand_loader.sv - self-checking bench for mac_operand_loader
//   Drives the word stream and MAC handshake, compares against a pair-queue model.
module tb_mac_operand_loader;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         op_valid;
  logic         op_ready;
  logic [255:0] a_out;
  logic [255:0] b_out;
`ifdef OPLD_LAST_CHK_EN
  logic         s_last;
  logic         err;
`endif

  mac_operand_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .a_out    (a_out),
    .b_out    (b_out)
`ifdef OPLD_LAST_CHK_EN
    ,
    .s_last   (s_last),
    .err      (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: words of the pair being assembled, and pairs owed to the MAC
  // (entry 0 is on the outputs, entry 1 is a complete pair waiting behind it).
  logic [31:0]  words[$];
  logic [255:0] exp_a[$];
  logic [255:0] exp_b[$];
  logic         exp_err;
  int           vecs;
  int           errs;
  int           hs_cnt;
  int           steps;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    words.delete();
    exp_a.delete();
    exp_b.delete();
    exp_err = 1'b0;
  endtask

  // Called at a falling edge: check current outputs, drive inputs, advance model
  // through the next rising edge, return at the following falling edge.
  task automatic step(input logic v, input logic [31:0] d, input logic rdy,
                      input logic fl, input logic lst, output logic acc);
    logic         hs;
    logic         bad;
    logic [255:0] a;
    logic [255:0] b;
    s_valid  = v;
    s_data   = d;
    op_ready = rdy;
    flush    = fl;
`ifdef OPLD_LAST_CHK_EN
    s_last   = lst;
    check("err", err, exp_err);
`endif
    check("s_ready", s_ready, exp_a.size() < 2);
    check("op_valid", op_valid, exp_a.size() > 0);
    if (exp_a.size() > 0) begin
      check("a_out", a_out, exp_a[0]);
      check("b_out", b_out, exp_b[0]);
    end
    hs  = (exp_a.size() > 0) && rdy;
    acc = v && (exp_a.size() < 2) && !fl;
    if (fl) begin
      words.delete();
      exp_err = 1'b0;
      if (exp_a.size() == 2) begin
        void'(exp_a.pop_back());
        void'(exp_b.pop_back());
      end
    end
    if (hs) begin
      void'(exp_a.pop_front());
      void'(exp_b.pop_front());
      hs_cnt++;
    end
    if (acc) begin
      bad = 1'b0;
`ifdef OPLD_LAST_CHK_EN
      bad = (lst != (words.size() == 15));
`endif
      if (bad) begin
        exp_err = 1'b1;
        words.delete();
      end else begin
        words.push_back(d);
        if (words.size() == 16) begin
          for (int k = 0; k < 8; k++) begin
            a[k*32 +: 32] = words[k];
            b[k*32 +: 32] = words[k+8];
          end
          exp_a.push_back(a);
          exp_b.push_back(b);
          words.delete();
        end
      end
    end
    steps++;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] d, input logic rdy, input logic lst);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) begin
      step(1'b1, d, rdy, 1'b0, lst, acc);
    end
    if (!acc) check("send_timeout", 256'd0, 256'd1);
  endtask

  function automatic logic [31:0] dword(input int k);
    return (k < 8) ? 32'hA000_0000 + k : 32'hB000_0000 + (k - 8);
  endfunction

  logic        acc_tmp;
  logic [31:0] f0;
  int          hs0;
  int          st0;

  initial begin
    vecs = 0; errs = 0; hs_cnt = 0; steps = 0;
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; op_ready = 1'b0;
`ifdef OPLD_LAST_CHK_EN
    s_last = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_s_ready", s_ready, 1);
    check("rst_op_valid", op_valid, 0);
    check("rst_a_out", a_out, 0);
    check("rst_b_out", b_out, 0);

    // 1: first pair, op_valid one cycle after the last word
    for (int k = 0; k < 16; k++) send_word(dword(k), 1'b1, k == 15);
    check("t1_op_valid", op_valid, 1);
    check("t1_a_lsw", a_out[31:0], 32'hA000_0000);
    check("t1_a_msw", a_out[255:224], 32'hA000_0007);
    check("t1_b_msw", b_out[255:224], 32'hB000_0007);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc_tmp);

    // 2: back-pressure fills both buffers, then one handshake frees the loader
    for (int k = 0; k < 32; k++) send_word($urandom, 1'b0, (k % 16) == 15);
    check("t2_s_ready_hold", s_ready, 0);
    check("t2_op_valid_hold", op_valid, 1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc_tmp);
    check("t2_s_ready_release", s_ready, 1);
    check("t2_op_valid_next", op_valid, 1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc_tmp);

    // 3: sustained streaming, one pair per 16 cycles with no stalls
    hs0 = hs_cnt;
    st0 = steps;
    for (int k = 0; k < 64; k++) send_word($urandom, 1'b1, (k % 16) == 15);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc_tmp);
    check("t3_handshakes", hs_cnt - hs0, 4);
    check("t3_cycles", steps - st0, 65);

    // 4: flush mid-pair drops the partial pair and the flush-cycle word
    for (int k = 0; k < 5; k++) send_word($urandom, 1'b1, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, acc_tmp);
    f0 = $urandom;
    send_word(f0, 1'b1, 1'b0);
    for (int k = 1; k < 16; k++) send_word($urandom, 1'b1, k == 15);
    check("t4_a_lsw", a_out[31:0], f0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc_tmp);

    // 5: asynchronous reset with a pair pending and another part-assembled
    for (int k = 0; k < 26; k++) send_word($urandom, 1'b0, (k % 16) == 15);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_op_valid", op_valid, 0);
    check("t5_async_a_out", a_out, 0);
    check("t5_async_b_out", b_out, 0);
    check("t5_async_s_ready", s_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) send_word(dword(k), 1'b0, k == 15);
    check("t5_a_after_rst", a_out, {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004,
                                    32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc_tmp);

`ifdef OPLD_LAST_CHK_EN
    // 6: early s_last sets sticky err, next framed pair still delivered
    for (int k = 0; k < 8; k++) send_word(dword(k), 1'b0, k == 7);
    check("t6_err_set", err, 1);
    check("t6_no_op_valid", op_valid, 0);
    for (int k = 0; k < 16; k++) send_word(dword(k), 1'b0, k == 15);
    check("t6_valid_pair", op_valid, 1);
    check("t6_err_sticky", err, 1);
    step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, acc_tmp);
    check("t6_err_cleared", err, 0);
`endif

    // Random traffic with occasional flush (and framing errors when checked)
    for (int i = 0; i < 400; i++) begin
      logic lst;
      lst = (words.size() == 15);
`ifdef OPLD_LAST_CHK_EN
      if ($urandom_range(0, 50) == 0) lst = !lst;
`endif
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0, lst, acc_tmp);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc_tmp);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
